vga_text_vram_sequencer: RTL and testbench

//  Owns VRAM port A of the VGA text display: shares it between the Avalon-MM host and a

---
 rtl/vga_text_pkg.sv | 33 +++
 rtl/vga_text_vram_sequencer.sv | 157 +++++++++++++++
 tb/tb_vga_text_vram_sequencer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_pkg.sv
// ============================================================================
// vga_text_pkg : geometry constants and enums shared by the VRAM sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package vga_text_pkg;

  localparam int ROWS          = 30;
  localparam int WORDS_PER_ROW = 20;
  localparam int VRAM_WORDS    = ROWS * WORDS_PER_ROW;
  localparam int SCROLL_WORDS  = VRAM_WORDS - WORDS_PER_ROW;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_SCROLL = 2'b10,
    OP_RSVD   = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLR_WR   = 3'd1,
    ST_SCR_RD   = 3'd2,
    ST_SCR_CAP  = 3'd3,
    ST_SCR_WR   = 3'd4,
    ST_SCR_FILL = 3'd5,
    ST_FIN      = 3'd6
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/vga_text_vram_sequencer.sv
// ============================================================================
// vga_text_vram_sequencer : shares VRAM port A between the Avalon host and a
// clear/scroll engine; the host always wins the port.
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_text_vram_sequencer
  import vga_text_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              AVL_CS,
  input  logic              AVL_READ,
  input  logic              AVL_WRITE,
  input  logic [3:0]        AVL_BYTE_EN,
  input  logic [ADDR_W-1:0] AVL_ADDR,
  input  logic [31:0]       AVL_WRITEDATA,
  output logic [31:0]       AVL_READDATA,
  input  logic              CMD_VALID,
  input  logic [1:0]        CMD_OP,
  input  logic [31:0]       CMD_FILL,
  output logic              CMD_READY,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [3:0]        RAM_BYTE_EN,
  output logic [31:0]       RAM_WDATA,
  output logic              RAM_RDEN,
  output logic              RAM_WREN,
  input  logic [31:0]       RAM_Q
);

  localparam logic [ADDR_W-1:0] PTR_LAST    = ADDR_W'(VRAM_WORDS - 1);
  localparam logic [ADDR_W-1:0] SCROLL_LAST = ADDR_W'(SCROLL_WORDS - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE  = ADDR_W'(WORDS_PER_ROW);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [31:0]       fill_q, fill_d;
  logic [31:0]       hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              host_req;
  logic              port_free;
  logic              eng_wr;
  logic              eng_rd;
  logic [ADDR_W-1:0] eng_addr;
  logic [31:0]       eng_wdata;
  cmd_op_e           cmd_op;

  assign host_req  = AVL_CS & (AVL_READ | AVL_WRITE);
  assign port_free = ~host_req;
  assign cmd_op    = cmd_op_e'(CMD_OP);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    fill_d    = fill_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    eng_wr    = 1'b0;
    eng_rd    = 1'b0;
    eng_addr  = ptr_q;
    eng_wdata = fill_q;

    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID && (cmd_op == OP_CLEAR || cmd_op == OP_SCROLL)) begin
          fill_d  = CMD_FILL;
          ptr_d   = '0;
          busy_d  = 1'b1;
          state_d = (cmd_op == OP_CLEAR) ? ST_CLR_WR : ST_SCR_RD;
        end
      end
      ST_CLR_WR, ST_SCR_FILL: begin
        eng_wr = 1'b1;
        if (port_free) begin
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == PTR_LAST) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end
        end
      end
      ST_SCR_RD: begin
        eng_rd   = 1'b1;
        eng_addr = ptr_q + ROW_STRIDE;
        if (port_free) state_d = ST_SCR_CAP;
      end
      ST_SCR_CAP: begin
        // Read data from the previous cycle is on RAM_Q regardless of who owns the port now
        hold_d  = RAM_Q;
        state_d = ST_SCR_WR;
      end
      ST_SCR_WR: begin
        eng_wr    = 1'b1;
        eng_wdata = hold_q;
        if (port_free) begin
          ptr_d   = ptr_q + 1'b1;
          state_d = (ptr_q == SCROLL_LAST) ? ST_SCR_FILL : ST_SCR_RD;
        end
      end
      ST_FIN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      fill_q  <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      fill_q  <= fill_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    if (host_req) begin
      RAM_ADDR    = AVL_ADDR;
      RAM_BYTE_EN = AVL_BYTE_EN;
      RAM_WDATA   = AVL_WRITEDATA;
      RAM_RDEN    = AVL_CS & AVL_READ;
      RAM_WREN    = AVL_CS & AVL_WRITE;
    end else begin
      RAM_ADDR    = eng_addr;
      RAM_BYTE_EN = 4'hF;
      RAM_WDATA   = eng_wdata;
      RAM_RDEN    = eng_rd;
      RAM_WREN    = eng_wr;
    end
  end

  assign AVL_READDATA = RAM_Q;
  assign CMD_READY    = (state_q == ST_IDLE);
  assign BUSY         = busy_q;
  assign DONE         = done_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_text_vram_sequencer.sv
// ============================================================================
// tb_vga_text_vram_sequencer : randomized scoreboard bench with a VRAM model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vga_text_vram_sequencer;
  import vga_text_pkg::*;

  localparam int AW = 10;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          AVL_CS, AVL_READ, AVL_WRITE;
  logic [3:0]    AVL_BYTE_EN;
  logic [AW-1:0] AVL_ADDR;
  logic [31:0]   AVL_WRITEDATA, AVL_READDATA;
  logic          CMD_VALID;
  logic [1:0]    CMD_OP;
  logic [31:0]   CMD_FILL;
  logic          CMD_READY, BUSY, DONE;
  logic [AW-1:0] RAM_ADDR;
  logic [3:0]    RAM_BYTE_EN;
  logic [31:0]   RAM_WDATA;
  logic          RAM_RDEN, RAM_WREN;
  logic [31:0]   RAM_Q;

  always #10 CLK = ~CLK;

  vga_text_vram_sequencer #(.ADDR_W(AW)) dut (
    .CLK(CLK), .RESET(RESET),
    .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR),
    .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
    .CMD_VALID(CMD_VALID), .CMD_OP(CMD_OP), .CMD_FILL(CMD_FILL),
    .CMD_READY(CMD_READY), .BUSY(BUSY), .DONE(DONE),
    .RAM_ADDR(RAM_ADDR), .RAM_BYTE_EN(RAM_BYTE_EN), .RAM_WDATA(RAM_WDATA),
    .RAM_RDEN(RAM_RDEN), .RAM_WREN(RAM_WREN), .RAM_Q(RAM_Q)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // VRAM port A model with registered read; ld_en bulk-loads a test image
  logic [31:0] mem    [0:1023];
  logic [31:0] ld_mem [0:1023];
  logic [31:0] expm   [0:1023];
  logic        ld_en = 1'b0;

  always @(posedge CLK) begin
    if (ld_en) begin
      for (int i = 0; i < 1024; i++) mem[i] <= ld_mem[i];
    end else begin
      if (RAM_WREN) mem[RAM_ADDR] <= merge(mem[RAM_ADDR], RAM_WDATA, RAM_BYTE_EN);
      if (RAM_RDEN) RAM_Q <= mem[RAM_ADDR];
    end
  end

  logic [31:0] cyc = '0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] done_exp[$];
  logic [31:0] rd_exp[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: host read data one cycle after the request, DONE against expected cycle
  logic rd_pend = 1'b0;
  always @(negedge CLK) begin
    if (rd_pend) begin
      if (rd_exp.size() != 0) chk("host_read", AVL_READDATA, rd_exp.pop_front());
      else chk("host_read_unexpected", AVL_READDATA, 32'hxxxx_xxxx);
    end
    rd_pend <= !RESET && AVL_CS && AVL_READ;
    if (!RESET && DONE) begin
      if (done_exp.size() != 0) chk("done_cycle", cyc, done_exp.pop_front());
      else chk("done_unexpected", 32'd1, 32'd0);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_idle();
    AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0; AVL_BYTE_EN = 4'hF;
    AVL_ADDR = '0; AVL_WRITEDATA = '0;
  endtask

  task automatic load(input int mode);
    for (int i = 0; i < 1024; i++) begin
      ld_mem[i] = (mode == 0) ? 32'(i) : $urandom;
      expm[i]   = ld_mem[i];
    end
    ld_en = 1'b1;
    tick();
    ld_en = 1'b0;
  endtask

  // Drive a command for one cycle; returns the accept cycle index
  task automatic issue(input logic [1:0] op, input logic [31:0] fill, output logic [31:0] a);
    CMD_VALID = 1'b1; CMD_OP = op; CMD_FILL = fill;
    a = cyc;
    tick();
    CMD_VALID = 1'b0; CMD_OP = 2'b00;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_exp.size() != 0 && n < budget) begin tick(); n++; end
    if (done_exp.size() != 0) begin
      chk("done_timeout", 32'(done_exp.size()), 32'd0);
      done_exp.delete();
    end
    tick();
  endtask

  task automatic check_mem(input string nm);
    int bad;
    bad = -1;
    for (int i = VRAM_WORDS - 1; i >= 0; i--) if (mem[i] !== expm[i]) bad = i;
    n_chk++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL %s: word %0d got %h expected %h", nm, bad, mem[bad], expm[bad]);
    end
  endtask

  task automatic scroll_model(input logic [31:0] fill);
    for (int i = 0; i < VRAM_WORDS; i++)
      expm[i] = (i < SCROLL_WORDS) ? expm[i + WORDS_PER_ROW] : fill;
  endtask

  initial begin : stim
    logic [31:0] a, f, d;
    logic [31:0] orig [0:1023];
    logic [3:0]  be;
    int          ad, eptr;

    RESET = 1'b1; CMD_VALID = 0; CMD_OP = 0; CMD_FILL = 0;
    bus_idle();
    tick(); tick();
    chk("rst_ready", 32'(CMD_READY), 32'd1);
    chk("rst_busy",  32'(BUSY), 32'd0);
    chk("rst_done",  32'(DONE), 32'd0);
    chk("rst_wren",  32'(RAM_WREN), 32'd0);
    chk("rst_rden",  32'(RAM_RDEN), 32'd0);
    RESET = 1'b0;
    tick();

    // NOP / reserved have no effect; out-of-range host address passes through
    issue(2'b00, 32'h1234_5678, a);
    chk("nop_busy", 32'(BUSY), 32'd0);
    chk("nop_ready", 32'(CMD_READY), 32'd1);
    issue(2'b11, 32'h1234_5678, a);
    chk("rsvd_busy", 32'(BUSY), 32'd0);
    AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 10'h3FF; AVL_WRITEDATA = 32'hCAFE_F00D;
    #1;
    chk("host_hi_addr", 32'(RAM_ADDR), 32'h3FF);
    chk("host_hi_wren", 32'(RAM_WREN), 32'd1);
    tick(); bus_idle(); tick();

    // CLEAR, no host traffic
    load(1);
    f = 32'h2020_2020;
    done_exp.push_back(cyc + 601);
    issue(2'b01, f, a);
    chk("clr_busy", 32'(BUSY), 32'd1);
    for (int i = 0; i < VRAM_WORDS; i++) expm[i] = f;
    wait_done(700);
    check_mem("clear_image");

    // SCROLL of word i = i
    load(0);
    done_exp.push_back(cyc + 1761);
    issue(2'b10, 32'h0, a);
    scroll_model(32'h0);
    wait_done(1900);
    check_mem("scroll_image");
    chk("scroll_w0", mem[0], 32'd20);
    chk("scroll_w579", mem[579], 32'd599);
    chk("scroll_w599", mem[599], 32'd0);

    // CLEAR with a host access on every odd cycle; word 5 read mid-operation
    load(1);
    f = $urandom;
    done_exp.push_back(cyc + 1201);
    issue(2'b01, f, a);
    eptr = 0;
    for (int c = 1; eptr < VRAM_WORDS && c < 1400; c++) begin
      bus_idle();
      if ((c % 2) == 1) begin
        AVL_CS = 1;
        if (c == 201) begin
          AVL_READ = 1; AVL_ADDR = 10'd5;
          rd_exp.push_back(expm[5]);
        end else begin
          ad = $urandom_range(0, VRAM_WORDS - 1);
          d  = $urandom; be = 4'($urandom);
          AVL_WRITE = 1; AVL_ADDR = AW'(ad); AVL_WRITEDATA = d; AVL_BYTE_EN = be;
          expm[ad] = merge(expm[ad], d, be);
        end
      end else begin
        expm[eptr] = f;
        eptr++;
      end
      tick();
    end
    bus_idle();
    wait_done(200);
    check_mem("clear_host_image");

    // SCROLL with host reads only during capture cycles (c = 3k+2), no stall
    load(1);
    for (int i = 0; i < 1024; i++) orig[i] = expm[i];
    f = $urandom;
    done_exp.push_back(cyc + 1761);
    issue(2'b10, f, a);
    for (int c = 1; c <= 1760; c++) begin
      bus_idle();
      if ((c % 3) == 2 && c < 1740 && $urandom_range(0, 3) == 0) begin
        ad = $urandom_range(0, VRAM_WORDS - 1);
        AVL_CS = 1; AVL_READ = 1; AVL_ADDR = AW'(ad);
        rd_exp.push_back((ad < SCROLL_WORDS && (3 * ad + 3) < c) ? orig[ad + WORDS_PER_ROW] : orig[ad]);
      end
      tick();
    end
    bus_idle();
    scroll_model(f);
    wait_done(100);
    check_mem("scroll_hostread_image");

    // Command during SCROLL is ignored
    load(1);
    f = $urandom;
    done_exp.push_back(cyc + 1761);
    issue(2'b10, f, a);
    for (int c = 1; c < 10; c++) tick();
    CMD_VALID = 1; CMD_OP = 2'b01; CMD_FILL = 32'hDEAD_BEEF;
    chk("busy_ready", 32'(CMD_READY), 32'd0);
    tick();
    CMD_VALID = 0; CMD_OP = 2'b00;
    scroll_model(f);
    wait_done(1900);
    check_mem("scroll_ignore_image");

    // RESET at cycle 300 of CLEAR
    load(1);
    f = $urandom;
    issue(2'b01, f, a);
    for (int c = 1; c < 300; c++) tick();
    RESET = 1'b1;
    #1;
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_wren", 32'(RAM_WREN), 32'd0);
    chk("abort_ready", 32'(CMD_READY), 32'd1);
    tick();
    RESET = 1'b0;
    for (int i = 0; i < 299; i++) expm[i] = f;
    check_mem("abort_image");
    f = ~f;
    done_exp.push_back(cyc + 601);
    issue(2'b01, f, a);
    chk("reclear_busy", 32'(BUSY), 32'd1);
    for (int i = 0; i < VRAM_WORDS; i++) expm[i] = f;
    wait_done(700);
    check_mem("reclear_image");

    tick(); tick();
    chk("rd_queue_empty", 32'(rd_exp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin : watchdog
    #(20 * 60000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
